// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster engine with renderer-latency-matched sync/blank outputs.
// Optional feature VGA_TESTPAT_EN adds input testpat selecting an 8-bar colour test pattern.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int COLOR_W  = 4,
    parameter int PIPE_DLY = 2,
    parameter int SYNC_POL = 0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
`ifdef VGA_TESTPAT_EN
    input  logic               testpat,
`endif
    input  logic [COLOR_W-1:0] red_in,
    input  logic [COLOR_W-1:0] green_in,
    input  logic [COLOR_W-1:0] blue_in,
    output logic [XW-1:0]      pix_x,
    output logic [YW-1:0]      pix_y,
    output logic               pix_req,
    output logic               pix_tick,
    output logic               line_start,
    output logic               frame_start,
    output logic               Hsync,
    output logic               Vsync,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);

    localparam int              PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [XW-1:0]   H_LAST     = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0]   V_LAST     = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0]   H_VIS      = XW'(H_ACTIVE);
    localparam logic [YW-1:0]   V_VIS      = YW'(V_ACTIVE);
    localparam logic [XW-1:0]   HS_FIRST   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0]   HS_LAST    = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0]   VS_FIRST   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0]   VS_LAST    = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic            SYNC_IDLE  = (SYNC_POL == 0);
    localparam logic [COLOR_W-1:0] CMAX    = '1;

    logic [PW-1:0]       presc;
    logic [XW-1:0]       hcnt;
    logic [YW-1:0]       vcnt;
    logic                tick;
    logic                h_wrap;
    logic                hs_p0, vs_p0, vld_p0;
    logic [PIPE_DLY-1:0] hs_dly, vs_dly, vld_dly;
    logic [COLOR_W-1:0]  r_nxt, g_nxt, b_nxt;

    // pulses are suppressed while held in reset or frozen
    assign tick   = rst_n && en && (presc == PRESC_LAST);
    assign h_wrap = (hcnt == H_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (en) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (tick) begin
            if (h_wrap) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // stage 0: raster position and its sync/active decode
    assign hs_p0       = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
    assign vs_p0       = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);
    assign vld_p0      = (hcnt < H_VIS) && (vcnt < V_VIS);
    assign pix_x       = hcnt;
    assign pix_y       = vcnt;
    assign pix_req     = vld_p0;
    assign pix_tick    = tick;
    assign line_start  = tick && (hcnt == '0);
    assign frame_start = tick && (hcnt == '0) && (vcnt == '0);

    // stages 1..PIPE_DLY: delay line matching the renderer colour latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_dly  <= '0;
            vs_dly  <= '0;
            vld_dly <= '0;
        end else if (tick) begin
            hs_dly[0]  <= hs_p0;
            vs_dly[0]  <= vs_p0;
            vld_dly[0] <= vld_p0;
            for (int i = 1; i < PIPE_DLY; i++) begin
                hs_dly[i]  <= hs_dly[i-1];
                vs_dly[i]  <= vs_dly[i-1];
                vld_dly[i] <= vld_dly[i-1];
            end
        end
    end

`ifdef VGA_TESTPAT_EN
    logic [XW-1:0] x_dly [PIPE_DLY];
    logic [2:0]    bar;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_DLY; i++) x_dly[i] <= '0;
        end else if (tick) begin
            x_dly[0] <= hcnt;
            for (int i = 1; i < PIPE_DLY; i++) x_dly[i] <= x_dly[i-1];
        end
    end

    // bar index only matters inside the active area, so truncation during blanking is harmless
    assign bar = 3'({x_dly[PIPE_DLY-1], 3'b000} / (XW+3)'(H_ACTIVE));
`endif

    always_comb begin
        r_nxt = red_in;
        g_nxt = green_in;
        b_nxt = blue_in;
`ifdef VGA_TESTPAT_EN
        if (testpat) begin
            r_nxt = bar[2] ? CMAX : '0;
            g_nxt = bar[1] ? CMAX : '0;
            b_nxt = bar[0] ? CMAX : '0;
        end
`endif
        if (!vld_dly[PIPE_DLY-1]) begin
            r_nxt = '0;
            g_nxt = '0;
            b_nxt = '0;
        end
    end

    // output register: pins change only in tick cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Hsync <= SYNC_IDLE;
            Vsync <= SYNC_IDLE;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (tick) begin
            Hsync <= hs_dly[PIPE_DLY-1] ^ SYNC_IDLE;
            Vsync <= vs_dly[PIPE_DLY-1] ^ SYNC_IDLE;
            red   <= r_nxt;
            green <= g_nxt;
            blue  <= b_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size line timing, reduced-size frame timing,
// prescaled enable freeze and asynchronous mid-frame reset.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    logic [3:0] rin, gin, bin;
    logic       testpat;

    // A: default 640x480 timing, CLK_DIV=1
    logic       rst_a, en_a;
    logic [9:0] x_a, y_a;
    logic       req_a, tick_a, ls_a, fs_a, hs_a, vs_a;
    logic [3:0] r_a, g_a, b_a;
    // B: reduced 16x8 timing (25x15 total), CLK_DIV=1
    logic       rst_b, en_b;
    logic [4:0] x_b;
    logic [3:0] y_b;
    logic       req_b, tick_b, ls_b, fs_b, hs_b, vs_b;
    logic [3:0] r_b, g_b, b_b;
    // C: reduced timing, CLK_DIV=4
    logic       rst_c, en_c;
    logic [4:0] x_c;
    logic [3:0] y_c;
    logic       req_c, tick_c, ls_c, fs_c, hs_c, vs_c;
    logic [3:0] r_c, g_c, b_c;

    vga_timing_gen #(.CLK_DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_a), .en(en_a),
`ifdef VGA_TESTPAT_EN
        .testpat(testpat),
`endif
        .red_in(rin), .green_in(gin), .blue_in(bin),
        .pix_x(x_a), .pix_y(y_a), .pix_req(req_a), .pix_tick(tick_a),
        .line_start(ls_a), .frame_start(fs_a), .Hsync(hs_a), .Vsync(vs_a),
        .red(r_a), .green(g_a), .blue(b_a));

    vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                     .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_b), .en(en_b),
`ifdef VGA_TESTPAT_EN
        .testpat(1'b0),
`endif
        .red_in(rin), .green_in(gin), .blue_in(bin),
        .pix_x(x_b), .pix_y(y_b), .pix_req(req_b), .pix_tick(tick_b),
        .line_start(ls_b), .frame_start(fs_b), .Hsync(hs_b), .Vsync(vs_b),
        .red(r_b), .green(g_b), .blue(b_b));

    vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                     .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .CLK_DIV(4)) dut_c (
        .clk(clk), .rst_n(rst_c), .en(en_c),
`ifdef VGA_TESTPAT_EN
        .testpat(1'b0),
`endif
        .red_in(rin), .green_in(gin), .blue_in(bin),
        .pix_x(x_c), .pix_y(y_c), .pix_req(req_c), .pix_tick(tick_c),
        .line_start(ls_c), .frame_start(fs_c), .Hsync(hs_c), .Vsync(vs_c),
        .red(r_c), .green(g_c), .blue(b_c));

    task automatic test_reset();
        rst_a = 0; rst_b = 0; rst_c = 0;
        en_a = 1; en_b = 1; en_c = 1;
        rin = 4'hF; gin = 4'h0; bin = 4'h0; testpat = 0;
        repeat (3) @(negedge clk);
        ntot++; if ({x_a, y_a} !== 20'd0) $display("FAIL rst_a_xy got %0d,%0d want 0,0", x_a, y_a); else npass++;
        ntot++; if ({hs_a, vs_a} !== 2'b11) $display("FAIL rst_a_sync got %b want 11", {hs_a, vs_a}); else npass++;
        ntot++; if ({r_a, g_a, b_a} !== 12'h000) $display("FAIL rst_a_rgb got %h want 000", {r_a, g_a, b_a}); else npass++;
        ntot++; if ({tick_a, ls_a, fs_a} !== 3'b000) $display("FAIL rst_a_pulses got %b want 000", {tick_a, ls_a, fs_a}); else npass++;
        ntot++; if ({hs_c, vs_c, r_c} !== 6'b110000) $display("FAIL rst_c_pins got %b want 110000", {hs_c, vs_c, r_c}); else npass++;
        rst_a = 1; rst_b = 1; rst_c = 1;
        #1;
        ntot++; if ({tick_a, ls_a, fs_a} !== 3'b111) $display("FAIL release_a_pulses got %b want 111", {tick_a, ls_a, fs_a}); else npass++;
        @(negedge clk);
        ntot++; if (x_a !== 10'd1) $display("FAIL release_a_x got %0d want 1", x_a); else npass++;
    endtask

    task automatic test_line_timing();
        int px, lows, reds, first_low, first_red, hs_err, r_err, g_err, n;
        logic exp_hs;
        logic [3:0] exp_r;
        lows = 0; reds = 0; first_low = -1; first_red = -1; hs_err = 0; r_err = 0; g_err = 0; n = 0;
        while (x_a !== 10'd0 && n < 1000) begin @(negedge clk); n++; end
        ntot++; if (x_a !== 10'd0) $display("FAIL line_sync_wait got x=%0d want 0", x_a); else npass++;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            px = (int'(x_a) + 797) % 800;
            exp_hs = !(px >= 656 && px <= 751);
            exp_r  = (px < 640) ? 4'hF : 4'h0;
            if (hs_a !== exp_hs) hs_err++;
            if (r_a !== exp_r) r_err++;
            if (g_a !== 4'h0 || b_a !== 4'h0) g_err++;
            if (hs_a === 1'b0) begin lows++; if (first_low < 0) first_low = int'(x_a); end
            if (r_a === 4'hF) begin reds++; if (first_red < 0) first_red = int'(x_a); end
        end
        ntot++; if (lows !== 96) $display("FAIL hsync_width got %0d want 96", lows); else npass++;
        ntot++; if (first_low !== 659) $display("FAIL hsync_start_x got %0d want 659", first_low); else npass++;
        ntot++; if (hs_err !== 0) $display("FAIL hsync_shape errors got %0d want 0", hs_err); else npass++;
        ntot++; if (reds !== 640) $display("FAIL red_count got %0d want 640", reds); else npass++;
        ntot++; if (first_red !== 3) $display("FAIL red_start_x got %0d want 3", first_red); else npass++;
        ntot++; if (r_err !== 0 || g_err !== 0) $display("FAIL rgb_shape errors got %0d,%0d want 0,0", r_err, g_err); else npass++;
    endtask

    task automatic test_frame();
        int n, cyc, reds, vlows, lines, vx, vy;
        logic prev_vs;
        n = 0;
        while (fs_b !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        ntot++; if (fs_b !== 1'b1) $display("FAIL frame_wait got fs=%b want 1", fs_b); else npass++;
        cyc = 0; reds = 0; vlows = 0; lines = 0; vx = -1; vy = -1; prev_vs = vs_b;
        do begin
            @(negedge clk);
            cyc++;
            if (r_b === 4'hF) reds++;
            if (vs_b === 1'b0) vlows++;
            if (ls_b === 1'b1) lines++;
            if (prev_vs === 1'b1 && vs_b === 1'b0 && vx < 0) begin vx = int'(x_b); vy = int'(y_b); end
            prev_vs = vs_b;
        end while (fs_b !== 1'b1 && cyc < 500);
        ntot++; if (cyc !== 375) $display("FAIL frame_period got %0d want 375", cyc); else npass++;
        ntot++; if (lines !== 15) $display("FAIL lines_per_frame got %0d want 15", lines); else npass++;
        ntot++; if (reds !== 128) $display("FAIL frame_red_count got %0d want 128", reds); else npass++;
        ntot++; if (vlows !== 50) $display("FAIL vsync_width got %0d want 50", vlows); else npass++;
        ntot++; if (vx !== 3 || vy !== 10) $display("FAIL vsync_start got x=%0d y=%0d want x=3 y=10", vx, vy); else npass++;
    endtask

    task automatic test_en_freeze();
        int n, err;
        logic [4:0] fx;
        logic [5:0] pins;
        n = 0;
        while (tick_c !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (tick_c !== 1'b1 && n < 20);
        ntot++; if (n !== 4) $display("FAIL tick_spacing got %0d want 4", n); else npass++;
        n = 0;
        while (!(tick_c === 1'b1 && x_c === 5'd7 && y_c < 4'd8) && n < 2000) begin @(negedge clk); n++; end
        ntot++; if (x_c !== 5'd7) $display("FAIL freeze_wait got x=%0d want 7", x_c); else npass++;
        fx = x_c;
        pins = {hs_c, vs_c, r_c};
        ntot++; if (r_c !== 4'hF) $display("FAIL freeze_red got %h want F", r_c); else npass++;
        en_c = 0;
        #1;
        ntot++; if ({tick_c, ls_c, fs_c} !== 3'b000) $display("FAIL freeze_pulses got %b want 000", {tick_c, ls_c, fs_c}); else npass++;
        err = 0;
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            if (x_c !== fx || tick_c !== 1'b0 || {hs_c, vs_c, r_c} !== pins) err++;
        end
        ntot++; if (err !== 0) $display("FAIL freeze_hold errors got %0d want 0", err); else npass++;
        en_c = 1;
        #1;
        ntot++; if (tick_c !== 1'b1 || x_c !== 5'd7) $display("FAIL resume_phase got tick=%b x=%0d want tick=1 x=7", tick_c, x_c); else npass++;
        @(negedge clk);
        ntot++; if (x_c !== 5'd8) $display("FAIL resume_next got %0d want 8", x_c); else npass++;
    endtask

    task automatic test_rst_mid();
        int n;
        n = 0;
        while (!(x_c === 5'd22 && y_c === 4'd5) && n < 2000) begin @(negedge clk); n++; end
        ntot++; if (x_c !== 5'd22 || y_c !== 4'd5) $display("FAIL rstmid_wait got x=%0d y=%0d want 22,5", x_c, y_c); else npass++;
        ntot++; if (hs_c !== 1'b0) $display("FAIL rstmid_pre_hsync got %b want 0", hs_c); else npass++;
        #2 rst_c = 0;
        #1;
        ntot++; if (x_c !== 5'd0 || y_c !== 4'd0) $display("FAIL rstmid_xy got %0d,%0d want 0,0", x_c, y_c); else npass++;
        ntot++; if ({hs_c, vs_c, r_c, g_c, b_c} !== 14'b11_0000_0000_0000) $display("FAIL rstmid_pins got %b want 11000000000000", {hs_c, vs_c, r_c, g_c, b_c}); else npass++;
        repeat (3) @(negedge clk);
        rst_c = 1;
        #1;
        ntot++; if (tick_c !== 1'b0) $display("FAIL rstmid_release_tick got %b want 0", tick_c); else npass++;
        n = 0;
        while (tick_c !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        ntot++; if (n !== 3) $display("FAIL rstmid_first_tick got %0d cycles want 3", n); else npass++;
        ntot++; if (fs_c !== 1'b1) $display("FAIL rstmid_frame_start got %b want 1", fs_c); else npass++;
    endtask

`ifdef VGA_TESTPAT_EN
    task automatic test_testpat();
        int n;
        n = 0;
        while (!(x_a === 10'd0 && y_a < 10'd470) && n < 420000) begin @(negedge clk); n++; end
        testpat = 1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (x_a === 10'd3) begin
                ntot++; if ({r_a, g_a, b_a} !== 12'h000) $display("FAIL testpat_px0 got %h want 000", {r_a, g_a, b_a}); else npass++;
            end
            if (x_a === 10'd83) begin
                ntot++; if ({r_a, g_a, b_a} !== 12'h00F) $display("FAIL testpat_px80 got %h want 00F", {r_a, g_a, b_a}); else npass++;
            end
            if (x_a === 10'd323) begin
                ntot++; if ({r_a, g_a, b_a} !== 12'hF00) $display("FAIL testpat_px320 got %h want F00", {r_a, g_a, b_a}); else npass++;
            end
            if (x_a === 10'd642) begin
                ntot++; if ({r_a, g_a, b_a} !== 12'hFFF) $display("FAIL testpat_px639 got %h want FFF", {r_a, g_a, b_a}); else npass++;
            end
        end
        testpat = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_line_timing();
        test_frame();
        test_en_freeze();
        test_rst_mid();
`ifdef VGA_TESTPAT_EN
        test_testpat();
`endif
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
